vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Parametrised N-port arbiter placed in front of the single-port VRAM (spram32k8 or wider), replacing the fixed two-port CPU/VDP memory multiplexer. It grants at most one memory access per cycle, serving real-time channels (video fetch) by fixed priority and all other channels by round-robin. A starvation guard bounds how long a non-real-time channel can wait. Reads return through a two-stage pipeline tagged by channel.

## Interface
- CHANNELS, 4, number of requesting channels, 2..8.
- RT_CHANNELS, 1, number of real-time channels, 0..CHANNELS-1. Channels 0..RT_CHANNELS-1 are real-time; the rest are round-robin.
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- STARVE_LIMIT, 0, number of consecutive real-time preemptions before a waiting round-robin channel is forced. 0 disables the guard.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  grant enable; when low, no new grant is issued.
- req_valid  in  CHANNELS  per-channel request; held until accepted.
- req_write  in  CHANNELS  1 = write, 0 = read.
- req_addr  in  CHANNELS*ADDR_W  flattened addresses; channel k occupies [k*ADDR_W +: ADDR_W].
- req_wdata  in  CHANNELS*DATA_W  flattened write data, same packing as req_addr.
- req_ready  out  CHANNELS  one-hot grant; a transfer occurs when valid and ready are both high.
- rd_valid  out  CHANNELS  one-cycle read-completion pulse for the owning channel.
- rd_data  out  DATA_W  read data, registered; holds until the next completion.
- grant_id  out  $clog2(CHANNELS)  index of the current grant; 0 when idle.
- starve_event  out  1  one-cycle pulse when the guard forces a grant.
- mem_addr  out  ADDR_W  memory address.
- mem_write  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous RAM output; valid one cycle after the address is presented.

## Operation
- Grant selection is combinational from the current state and req_valid. It is qualified by ce, and at most one bit of req_ready is high.
- Priority order:
  1. Forced round-robin grant (guard).
  2. Lowest-index valid real-time channel.
  3. Round-robin winner: the first valid non-RT channel searching upward from rr_ptr, wrapping from CHANNELS-1 back to RT_CHANNELS.
- After a non-RT grant to channel k, rr_ptr becomes k+1, wrapping to RT_CHANNELS. rr_ptr is unchanged by real-time grants.
- Memory outputs while granted: mem_addr = granted address, mem_wdata = granted wdata, mem_write = req_write of the granted channel.
- Memory outputs while idle (or ce low): mem_addr = 0, mem_wdata = 0, mem_write = 0.
- Requester rules: addr, wdata and write must stay stable while valid is high and ready is low. Dropping valid before ready is permitted; the request is simply withdrawn.
- Starvation guard (STARVE_LIMIT > 0):
  - starve_ctr increments on each ce cycle in which a real-time grant occurs while at least one non-RT channel is valid.
  - It clears on any non-RT grant.
  - When starve_ctr == STARVE_LIMIT, the round-robin winner is granted instead of the real-time channel, starve_event pulses, and starve_ctr clears.
  - Counter width is $clog2(STARVE_LIMIT+1); it never exceeds STARVE_LIMIT.
- RT_CHANNELS = 0: pure round-robin; the guard is inert and starve_event stays 0.
- A write followed by a read of the same address in a later cycle returns the new data. No write buffering occurs.

## Timing
- Write: committed at the clock edge ending the grant cycle; no further response.
- Read granted in cycle N:
  - mem_rdata is valid in N+1.
  - rd_data captures it at the end of N+1.
  - rd_valid[k] is high for exactly cycle N+2.
- Throughput is one access per cycle. Back-to-back reads from any mix of channels complete in grant order with a fixed two-cycle latency.
- The read pipeline (channel tag and valid) advances every clk regardless of ce. ce gates only new grants.
- Reset values: req_ready 0, rd_valid 0, rd_data 0, grant_id 0, starve_event 0, mem_* 0, rr_ptr = RT_CHANNELS, starve_ctr 0.
- Reset asserted mid-operation: in-flight reads are discarded and no rd_valid is produced for them. After reset deasserts, the first grant can occur in that same cycle.

## Test plan
- Single read: CHANNELS=4, RT_CHANNELS=1. Preload 0x1234 = 0xA5; ch2 reads 0x1234 in cycle 0 -> req_ready[2] in cycle 0, mem_addr = 0x1234, rd_valid[2] in cycle 2 only, rd_data = 0xA5 from cycle 2 until the next completion.
- Contention: ch0, ch1, ch2 and ch3 all valid and held -> ch0 granted every cycle; ch1–3 never granted (STARVE_LIMIT=0). Drop ch0 -> grants go 1, 2, 3, 1 in successive cycles.
- Starvation guard: STARVE_LIMIT=3; ch0 and ch2 held valid -> grants 0, 0, 0, 2 (starve_event pulses with the ch2 grant), then 0, 0, 0, 2 repeating.
- Write-then-read: ch1 writes 0x0010 = 0x3C in cycle 0; ch3 reads 0x0010 in cycle 1 -> mem_write is high only in cycle 0; rd_valid[3] in cycle 3 with rd_data = 0x3C.
- ce and reset: ce=0 with ch1 valid -> no req_ready and mem_write 0. A read granted at cycle 5, then reset pulled low in cycle 6 -> no rd_valid in cycle 7; all outputs 0 and rr_ptr = 1 after reset.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: requester-side bus of the VRAM arbiter.
//   req_valid/req_write  per-channel request and direction (1 = write)
//   req_addr/req_wdata   flattened per-channel address / write data,
//                        channel k at [k*W +: W]
//   req_ready            one-hot grant back to the requesters
//   rd_valid/rd_data     read completion pulse (owning channel) and data
//   grant_id             index of the current grant, 0 when idle
//   starve_event         pulse when the starvation guard forces a grant
// modport master = requester side, modport slave = arbiter side.
interface vram_arbiter_if #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8
);
  logic [CHANNELS-1:0]          req_valid;
  logic [CHANNELS-1:0]          req_write;
  logic [CHANNELS*ADDR_W-1:0]   req_addr;
  logic [CHANNELS*DATA_W-1:0]   req_wdata;
  logic [CHANNELS-1:0]          req_ready;
  logic [CHANNELS-1:0]          rd_valid;
  logic [DATA_W-1:0]            rd_data;
  logic [$clog2(CHANNELS)-1:0]  grant_id;
  logic                         starve_event;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rd_valid, rd_data, grant_id, starve_event
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rd_valid, rd_data, grant_id, starve_event
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: N-port arbiter in front of a single-port synchronous VRAM.
// Real-time channels (0..RT_CHANNELS-1) win by fixed priority, the rest share
// by round-robin; an optional starvation guard forces a round-robin grant after
// STARVE_LIMIT consecutive real-time preemptions. Reads return two cycles after
// the grant through a channel-tagged pipeline.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   ce         grant enable (read pipeline keeps advancing when low)
//   bus        requester bus (vram_arbiter_if.slave)
//   mem_addr/mem_write/mem_wdata  memory request, zero when idle
//   mem_rdata  synchronous RAM read data (one cycle after address)
module vram_arbiter #(
  parameter int CHANNELS     = 4,
  parameter int RT_CHANNELS  = 1,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  vram_arbiter_if.slave        bus,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_write,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
);

  localparam int IW  = $clog2(CHANNELS);
  localparam int NRT = CHANNELS - RT_CHANNELS;
  localparam int SW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam bit GUARD_ON = (STARVE_LIMIT > 0) && (RT_CHANNELS > 0);

  localparam logic [IW-1:0] RR_BASE = IW'(RT_CHANNELS);
  localparam logic [IW-1:0] LAST    = IW'(CHANNELS - 1);
  localparam logic [IW:0]   LAST_X  = (IW+1)'(CHANNELS - 1);
  localparam logic [IW:0]   NRT_X   = (IW+1)'(NRT);
  localparam logic [SW-1:0] LIMIT   = SW'(STARVE_LIMIT);

  logic [IW-1:0]       rr_ptr;
  logic [SW-1:0]       starve_ctr;
  logic                rd1_valid;
  logic [IW-1:0]       rd1_id;
  logic [CHANNELS-1:0] rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic          rt_any, rr_any, force_rr;
  logic [IW-1:0] rt_idx, rr_idx;
  logic [IW:0]   rr_sum;
  logic          gnt_any, gnt_rr, gnt_write;
  logic [IW-1:0] gnt_idx;

  // Candidate search. Both loops run downward so the lowest index / the
  // smallest offset from rr_ptr is the last assignment and therefore wins.
  always_comb begin
    rt_any = 1'b0;
    rt_idx = '0;
    for (int i = RT_CHANNELS - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        rt_any = 1'b1;
        rt_idx = IW'(i);
      end
    end

    rr_any = 1'b0;
    rr_idx = '0;
    rr_sum = '0;
    for (int i = NRT - 1; i >= 0; i--) begin
      // rr_ptr + offset can exceed CHANNELS-1 by less than NRT, so a single
      // subtraction wraps it back into the non-RT range.
      rr_sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (rr_sum > LAST_X) rr_sum = rr_sum - NRT_X;
      if (bus.req_valid[rr_sum[IW-1:0]]) begin
        rr_any = 1'b1;
        rr_idx = rr_sum[IW-1:0];
      end
    end
  end

  // Guard only matters when a real-time channel would otherwise win.
  assign force_rr = GUARD_ON && (starve_ctr == LIMIT) && rt_any && rr_any;

  always_comb begin
    gnt_any = 1'b0;
    gnt_rr  = 1'b0;
    gnt_idx = '0;
    if (ce && reset) begin
      if (force_rr) begin
        gnt_any = 1'b1;
        gnt_rr  = 1'b1;
        gnt_idx = rr_idx;
      end else if (rt_any) begin
        gnt_any = 1'b1;
        gnt_idx = rt_idx;
      end else if (rr_any) begin
        gnt_any = 1'b1;
        gnt_rr  = 1'b1;
        gnt_idx = rr_idx;
      end
    end
  end

  assign gnt_write = bus.req_write[gnt_idx];

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_any && (gnt_idx == IW'(i))) begin
        mem_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
        mem_write = gnt_write;
      end
    end
  end

  assign bus.req_ready    = gnt_any ? (CHANNELS'(1) << gnt_idx) : '0;
  assign bus.grant_id     = gnt_idx;
  assign bus.starve_event = gnt_any && force_rr;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= RR_BASE;
      starve_ctr <= '0;
      rd1_valid  <= 1'b0;
      rd1_id     <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      if (gnt_any && gnt_rr) begin
        rr_ptr <= (gnt_idx == LAST) ? RR_BASE : gnt_idx + 1'b1;
      end

      if (GUARD_ON) begin
        if (gnt_any && gnt_rr) begin
          starve_ctr <= '0;
        end else if (gnt_any && rr_any && (starve_ctr != LIMIT)) begin
          starve_ctr <= starve_ctr + 1'b1;
        end
      end

      // Read pipeline advances every cycle, independent of ce.
      rd1_valid  <= gnt_any && !gnt_write;
      rd1_id     <= gnt_idx;
      rd_valid_q <= rd1_valid ? (CHANNELS'(1) << rd1_id) : '0;
      if (rd1_valid) rd_data_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: dut_a (4 ch, 1 RT, no guard) with a RAM
// model, dut_b (4 ch, 1 RT, STARVE_LIMIT=3) for guard arbitration.
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vram_arbiter_if #(.CHANNELS(4), .ADDR_W(16), .DATA_W(8)) bus_a ();
  vram_arbiter_if #(.CHANNELS(4), .ADDR_W(16), .DATA_W(8)) bus_b ();

  logic [15:0] mem_addr_a, mem_addr_b;
  logic        mem_write_a, mem_write_b;
  logic [7:0]  mem_wdata_a, mem_wdata_b;
  logic [7:0]  mem_rdata_a;
  logic [7:0]  mem_rdata_b;
  logic [7:0]  ram [0:65535];

  assign mem_rdata_b = 8'h00;

  vram_arbiter #(.CHANNELS(4), .RT_CHANNELS(1), .ADDR_W(16), .DATA_W(8),
                 .STARVE_LIMIT(0)) dut_a (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus_a),
    .mem_addr(mem_addr_a), .mem_write(mem_write_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a));

  vram_arbiter #(.CHANNELS(4), .RT_CHANNELS(1), .ADDR_W(16), .DATA_W(8),
                 .STARVE_LIMIT(3)) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus_b),
    .mem_addr(mem_addr_b), .mem_write(mem_write_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b));

  // Synchronous RAM: read returns the pre-write contents, write lands at the edge.
  always @(posedge clk) begin
    mem_rdata_a <= ram[mem_addr_a];
    if (mem_write_a) ram[mem_addr_a] = mem_wdata_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic req_a(input int ch, input bit v, input bit w,
                       input logic [15:0] a, input logic [7:0] d);
    bus_a.req_valid[ch]          = v;
    bus_a.req_write[ch]          = w;
    bus_a.req_addr[ch*16 +: 16]  = a;
    bus_a.req_wdata[ch*8 +: 8]   = d;
  endtask

  logic [1:0] gseq [0:6];

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1234] = 8'hA5;
    for (int k = 0; k < 4; k++) ram[16'h0100 + k] = 8'h10 + 8'(k);
    bus_a.req_valid = '0; bus_a.req_write = '0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = '0; bus_b.req_write = '0; bus_b.req_addr = '0; bus_b.req_wdata = '0;

    // Reset state with a request pending: nothing may be granted.
    req_a(1, 1'b1, 1'b1, 16'h0055, 8'h99);
    #1;
    chk("rst_ready", bus_a.req_ready, 4'b0000);
    chk("rst_rd_valid", bus_a.rd_valid, 4'b0000);
    chk("rst_rd_data", bus_a.rd_data, 8'h00);
    chk("rst_grant_id", bus_a.grant_id, 2'd0);
    chk("rst_mem_write", mem_write_a, 1'b0);
    chk("rst_mem_addr", mem_addr_a, 16'h0000);
    chk("rst_starve_b", bus_b.starve_event, 1'b0);
    req_a(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    step(); reset = 1'b1;

    // Single read: ch2 reads 0x1234.
    step(); req_a(2, 1'b1, 1'b0, 16'h1234, 8'h00); #1;
    chk("rd_c0_ready", bus_a.req_ready, 4'b0100);
    chk("rd_c0_addr", mem_addr_a, 16'h1234);
    chk("rd_c0_gid", bus_a.grant_id, 2'd2);
    chk("rd_c0_write", mem_write_a, 1'b0);
    step(); req_a(2, 1'b0, 1'b0, 16'h0000, 8'h00); #1;
    chk("rd_c1_rdv", bus_a.rd_valid, 4'b0000);
    chk("rd_c1_addr_idle", mem_addr_a, 16'h0000);
    step(); #1;
    chk("rd_c2_rdv", bus_a.rd_valid, 4'b0100);
    chk("rd_c2_data", bus_a.rd_data, 8'hA5);
    step(); #1;
    chk("rd_c3_rdv", bus_a.rd_valid, 4'b0000);
    chk("rd_c3_data_hold", bus_a.rd_data, 8'hA5);

    // Contention from a fresh rr_ptr: 0,0,0 then (ch0 dropped) 1,2,3,1.
    step(); reset = 1'b0;
    step(); reset = 1'b1;
    gseq[0] = 2'd0; gseq[1] = 2'd0; gseq[2] = 2'd0;
    gseq[3] = 2'd1; gseq[4] = 2'd2; gseq[5] = 2'd3; gseq[6] = 2'd1;
    for (int j = 0; j < 9; j++) begin
      step();
      if (j == 0) for (int k = 0; k < 4; k++) req_a(k, 1'b1, 1'b0, 16'h0100 + 16'(k), 8'h00);
      if (j == 3) req_a(0, 1'b0, 1'b0, 16'h0000, 8'h00);
      if (j == 7) for (int k = 0; k < 4; k++) req_a(k, 1'b0, 1'b0, 16'h0000, 8'h00);
      #1;
      if (j < 7) chk($sformatf("cont_ready_%0d", j), bus_a.req_ready, 4'b0001 << gseq[j]);
      if (j >= 2) begin
        chk($sformatf("cont_rdv_%0d", j), bus_a.rd_valid, 4'b0001 << gseq[j-2]);
        chk($sformatf("cont_rdd_%0d", j), bus_a.rd_data, 8'h10 + 8'(gseq[j-2]));
      end
    end

    // Starvation guard on dut_b: 0,0,0,2 repeating, starve_event with ch2.
    step();
    bus_b.req_valid = 4'b0101;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk($sformatf("starve_ready_%0d", j), bus_b.req_ready, (j % 4 == 3) ? 4'b0100 : 4'b0001);
      chk($sformatf("starve_event_%0d", j), bus_b.starve_event, (j % 4 == 3) ? 1'b1 : 1'b0);
      step();
    end
    bus_b.req_valid = 4'b0000;

    // Write then read of the same address.
    req_a(1, 1'b1, 1'b1, 16'h0010, 8'h3C); #1;
    chk("wr_c0_ready", bus_a.req_ready, 4'b0010);
    chk("wr_c0_write", mem_write_a, 1'b1);
    chk("wr_c0_wdata", mem_wdata_a, 8'h3C);
    chk("wr_c0_addr", mem_addr_a, 16'h0010);
    step(); req_a(1, 1'b0, 1'b0, 16'h0000, 8'h00); req_a(3, 1'b1, 1'b0, 16'h0010, 8'h00); #1;
    chk("wr_c1_ready", bus_a.req_ready, 4'b1000);
    chk("wr_c1_write", mem_write_a, 1'b0);
    step(); req_a(3, 1'b0, 1'b0, 16'h0000, 8'h00); #1;
    chk("wr_c2_write", mem_write_a, 1'b0);
    chk("wr_c2_rdv", bus_a.rd_valid, 4'b0000);
    step(); #1;
    chk("wr_c3_rdv", bus_a.rd_valid, 4'b1000);
    chk("wr_c3_data", bus_a.rd_data, 8'h3C);

    // ce low blocks grants; ce high releases the held request.
    step(); ce = 1'b0; req_a(1, 1'b1, 1'b1, 16'h0020, 8'h77); #1;
    chk("ce0_ready", bus_a.req_ready, 4'b0000);
    chk("ce0_write", mem_write_a, 1'b0);
    chk("ce0_addr", mem_addr_a, 16'h0000);
    chk("ce0_gid", bus_a.grant_id, 2'd0);
    step(); ce = 1'b1; #1;
    chk("ce1_ready", bus_a.req_ready, 4'b0010);
    chk("ce1_write", mem_write_a, 1'b1);

    // Read pipeline keeps running while ce is low.
    step(); req_a(1, 1'b0, 1'b0, 16'h0000, 8'h00); req_a(2, 1'b1, 1'b0, 16'h1234, 8'h00); #1;
    chk("cep_ready", bus_a.req_ready, 4'b0100);
    step(); ce = 1'b0; req_a(2, 1'b0, 1'b0, 16'h0000, 8'h00);
    step(); #1;
    chk("cep_rdv", bus_a.rd_valid, 4'b0100);
    chk("cep_rdd", bus_a.rd_data, 8'hA5);

    // Reset mid-read: ch2 read granted, reset next cycle, no completion.
    // rr_ptr is 3 before reset; ch1 winning afterwards shows it returned to 1.
    step(); ce = 1'b1; req_a(2, 1'b1, 1'b0, 16'h0011, 8'h00); #1;
    chk("mr_ready", bus_a.req_ready, 4'b0100);
    step(); req_a(2, 1'b0, 1'b0, 16'h0000, 8'h00); reset = 1'b0;
    req_a(1, 1'b1, 1'b0, 16'h0001, 8'h00); req_a(3, 1'b1, 1'b0, 16'h0003, 8'h00); #1;
    chk("mr_rst_ready", bus_a.req_ready, 4'b0000);
    chk("mr_rst_rdv", bus_a.rd_valid, 4'b0000);
    chk("mr_rst_rdd", bus_a.rd_data, 8'h00);
    chk("mr_rst_addr", mem_addr_a, 16'h0000);
    step(); reset = 1'b1; #1;
    chk("mr_post_rdv", bus_a.rd_valid, 4'b0000);
    chk("mr_post_ready", bus_a.req_ready, 4'b0010);
    chk("mr_post_gid", bus_a.grant_id, 2'd1);
    step(); req_a(1, 1'b0, 1'b0, 16'h0000, 8'h00); req_a(3, 1'b0, 1'b0, 16'h0000, 8'h00);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
